pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Sequences the 16-bit program counter as two 8-bit bytes, PCL and PCH, using the 6502's two-cycle carry behaviour.
- Handles increment, absolute jump and signed relative branch, including the page-crossing fix-up cycle.
- Drives the PC bus that feeds the program counter select register and the increment logic.
- Takes one-cycle request pulses from the instruction decoder and returns busy/done status.

Parameters:
- RESET_PC, 16'hFFFC, value loaded into the PC on reset (the reset vector fetch address).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inc_req  input  1  request PC <= PC + 1.
- jump_req  input  1  request PC <= jump_adr.
- jump_adr  input  16  absolute target address.
- branch_req  input  1  request PC <= PC + sign-extended branch_off.
- branch_off  input  8  signed two's-complement branch offset.
- pc  output  16  current program counter, {PCH, PCL}.
- busy  output  1  high while an operation is in progress; requests are ignored while high.
- done  output  1  one-cycle pulse in the cycle after the final PC update.
- page_cross  output  1  one-cycle pulse coincident with the PCH fix-up edge of a branch.

Behaviour:
- Reset: this is already decided — one clock; reset is synchronous and active-high.
  - On a rising clk edge with reset=1: pc=RESET_PC, state=IDLE, busy=0, done=0, page_cross=0.
  - Reset overrides any operation in progress. A half-finished carry or branch fix-up is abandoned.
- States: IDLE, CARRY_HI, BR_FIX.
- Request acceptance:
  - Requests are sampled only in IDLE.
  - Priority when several are high: jump_req > branch_req > inc_req. Lower-priority requests in the same cycle are dropped.
- Jump:
  - In IDLE with jump_req: pc <= jump_adr on one edge.
  - done pulses the next cycle. Latency is 1 cycle.
- Increment:
  - In IDLE with inc_req: PCL <= PCL+1 (8-bit).
  - If PCL was 8'hFF, move to CARRY_HI with busy=1. On the next edge PCH <= PCH+1 (8-bit wrap), then return to IDLE.
  - Otherwise stay in IDLE.
  - done pulses in the cycle after the last byte update.
  - Latency is 1 cycle, or 2 cycles on a low-byte wrap.
  - 16'hFFFF increments to 16'h0000 over 2 cycles.
- Branch:
  - In IDLE with branch_req, compute a 9-bit sum {1'b0,PCL} + {1'b0,branch_off}, then set PCL <= sum[7:0].
  - Page crossing occurs when:
    - branch_off is non-negative and sum[8]=1 (forward crossing), or
    - branch_off is negative and sum[8]=0 (backward crossing).
  - With no crossing: done next cycle, latency 1.
  - With a crossing: go to BR_FIX with busy=1. On the next edge set PCH <= PCH+1 (forward) or PCH-1 (backward), with 8-bit wrap, and pulse page_cross on that edge. Return to IDLE and pulse done the following cycle. Latency is 2.
  - Offset 0 leaves the PC unchanged and completes in 1 cycle.
- Intermediate pc value: during CARRY_HI and BR_FIX, pc shows the new PCL with the old PCH. This matches 6502 bus behaviour and is visible to consumers.
- Status outputs:
  - busy is registered and is high exactly in CARRY_HI and BR_FIX.
  - done and page_cross are registered single-cycle pulses. They never stay high for two consecutive cycles from one request.
- Back-to-back requests: a request presented in the cycle done is high, with state IDLE, is accepted.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined:
  - Adds output port prev_pc (16 bits), reset to RESET_PC.
  - On acceptance of a jump_req or branch_req, prev_pc <= the pc value before the update. It holds otherwise.
  - Increments never change prev_pc.
- Undefined: port prev_pc and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset for 2 cycles with jump_req=1 -> pc=16'hFFFC, busy=0, done=0, and the jump is ignored.
- Increment with carry:
  - pc=16'h12FE, two inc_req pulses spaced by done -> pc=16'h12FF after 1 cycle.
  - Then pc=16'h1300 after 2 more cycles, with busy=1 for one cycle and the intermediate pc=16'h1200.
- Forward branch:
  - pc=16'h20F0, branch_off=8'h20 -> PCL=8'h10, then pc=16'h2110, page_cross pulsed once, done 2 cycles after the request.
  - Repeat from 16'h2010 with offset 8'h20 -> pc=16'h2030 in 1 cycle, no page_cross.
- Backward branch:
  - pc=16'h3005, branch_off=8'hF0 (-16) -> pc=16'h2FF5 after 2 cycles, page_cross=1 once.
  - pc=16'h0005 with the same offset wraps to 16'hFFF5.
- Priority and busy:
  - jump_req and inc_req together with jump_adr=16'hC000 -> pc=16'hC000, no increment.
  - inc_req asserted during CARRY_HI is ignored, and pc ends at the expected value.
- Reset mid-operation: reset asserted in BR_FIX -> pc=16'hFFFC next edge, busy=0, no page_cross or done pulse.
- With PC_TRACE_EN defined: a jump from 16'h1234 -> prev_pc=16'h1234.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: 6502-style program counter sequencer.
// The 16-bit PC is held as two bytes (PCH, PCL). A carry or borrow out of the
// low byte costs one extra cycle to fix up the high byte. The PC supports
// increment, absolute jump and signed relative branch.
// Optional feature: define PC_TRACE_EN to add the prev_pc output, which records
// the PC value from before each accepted jump or branch.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_req,
  input  logic        jump_req,
  input  logic [15:0] jump_adr,
  input  logic        branch_req,
  input  logic [7:0]  branch_off,
  output logic [15:0] pc,
  output logic        busy,
  output logic        done,
  output logic        page_cross
`ifdef PC_TRACE_EN
  ,
  output logic [15:0] prev_pc
`endif
);

  typedef enum logic [1:0] {StIdle, StCarryHi, StBrFix} state_e;

  state_e     state_q;
  logic [7:0] pcl_q;
  logic [7:0] pch_q;
  logic       busy_q;
  logic       done_q;
  logic       page_cross_q;
  logic       br_back_q;     // direction of the pending PCH fix-up: 1 = decrement

  logic [8:0] br_sum;
  logic       br_cross;

  // Low-byte branch adder and page-crossing detection
  always_comb begin
    br_sum   = {1'b0, pcl_q} + {1'b0, branch_off};
    // A negative offset adds 256-|off|: no carry out then means a borrow
    br_cross = branch_off[7] ? ~br_sum[8] : br_sum[8];
  end

  // Sequencer FSM: PC bytes, state and registered status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pcl_q        <= RESET_PC[7:0];
      pch_q        <= RESET_PC[15:8];
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      page_cross_q <= 1'b0;
      br_back_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      page_cross_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (jump_req) begin
            pch_q  <= jump_adr[15:8];
            pcl_q  <= jump_adr[7:0];
            done_q <= 1'b1;
          end else if (branch_req) begin
            pcl_q <= br_sum[7:0];
            if (br_cross) begin
              state_q   <= StBrFix;
              busy_q    <= 1'b1;
              br_back_q <= branch_off[7];
            end else begin
              done_q <= 1'b1;
            end
          end else if (inc_req) begin
            pcl_q <= pcl_q + 8'd1;
            if (pcl_q == 8'hFF) begin
              state_q <= StCarryHi;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StCarryHi: begin
          pch_q   <= pch_q + 8'd1;
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        StBrFix: begin
          pch_q        <= br_back_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
          state_q      <= StIdle;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          page_cross_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_TRACE_EN
  logic [15:0] prev_pc_q;

  // Capture the pre-update PC on every accepted jump or branch
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_q <= RESET_PC;
    end else if (state_q == StIdle && (jump_req || branch_req)) begin
      prev_pc_q <= {pch_q, pcl_q};
    end
  end

  assign prev_pc = prev_pc_q;
`endif

  // During a fix-up cycle pc shows the new PCL with the old PCH
  assign pc         = {pch_q, pcl_q};
  assign busy       = busy_q;
  assign done       = done_q;
  assign page_cross = page_cross_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed steps followed by random requests,
// all checked against a 16-bit arithmetic reference model.
// Define PC_TRACE_EN to also check prev_pc.
module tb_pc_sequencer;

  localparam logic [15:0] ResetPc = 16'hFFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc_req;
  logic        jump_req;
  logic [15:0] jump_adr;
  logic        branch_req;
  logic [7:0]  branch_off;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        page_cross;
`ifdef PC_TRACE_EN
  logic [15:0] prev_pc;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_prev;

  pc_sequencer #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inc_req    (inc_req),
    .jump_req   (jump_req),
    .jump_adr   (jump_adr),
    .branch_req (branch_req),
    .branch_off (branch_off),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .page_cross (page_cross)
`ifdef PC_TRACE_EN
    ,
    .prev_pc    (prev_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic p);
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
    chk({tag, ".done"}, {15'd0, done}, {15'd0, d});
    chk({tag, ".page_cross"}, {15'd0, page_cross}, {15'd0, p});
  endtask

  task automatic chk_prev(input string tag);
`ifdef PC_TRACE_EN
    chk({tag, ".prev_pc"}, prev_pc, m_prev);
`else
    n_cmp = n_cmp + 0;
`endif
  endtask

  // Called at a negedge; presents a request for one cycle and checks the
  // whole operation. With poke set, extra requests are driven during a busy
  // cycle and must be ignored.
  task automatic issue(input string tag, input logic j, input logic b, input logic i,
                       input logic [15:0] adr, input logic [7:0] off, input logic poke);
    logic [15:0] exp_pc;
    logic [15:0] mid_pc;
    logic [15:0] sext;
    logic        two;
    logic        pcx;
    logic        acc;
    two = 1'b0;
    pcx = 1'b0;
    acc = 1'b1;
    exp_pc = m_pc;
    mid_pc = m_pc;
    if (j) begin
      exp_pc = adr;
      m_prev = m_pc;
    end else if (b) begin
      sext   = {{8{off[7]}}, off};
      exp_pc = m_pc + sext;
      two    = (exp_pc[15:8] != m_pc[15:8]);
      pcx    = two;
      mid_pc = {m_pc[15:8], exp_pc[7:0]};
      m_prev = m_pc;
    end else if (i) begin
      exp_pc = m_pc + 16'd1;
      two    = (m_pc[7:0] == 8'hFF);
      mid_pc = {m_pc[15:8], exp_pc[7:0]};
    end else begin
      acc = 1'b0;
    end
    jump_req   = j;
    branch_req = b;
    inc_req    = i;
    jump_adr   = adr;
    branch_off = off;
    @(negedge clk);
    jump_req   = 1'b0;
    branch_req = 1'b0;
    inc_req    = 1'b0;
    if (two) begin
      chk({tag, ".mid_pc"}, pc, mid_pc);
      chk_status({tag, ".mid"}, 1'b1, 1'b0, 1'b0);
      if (poke) begin
        inc_req  = 1'b1;
        jump_req = 1'b1;
        jump_adr = 16'($urandom);
      end
      @(negedge clk);
      inc_req  = 1'b0;
      jump_req = 1'b0;
    end
    m_pc = exp_pc;
    chk({tag, ".pc"}, pc, exp_pc);
    chk_status({tag, ".end"}, 1'b0, acc, pcx);
    chk_prev(tag);
  endtask

  initial begin
    logic        rj, rb, ri;
    logic [15:0] radr;
    logic [7:0]  roff;

    reset      = 1'b1;
    inc_req    = 1'b0;
    jump_req   = 1'b1;
    jump_adr   = 16'h1234;
    branch_req = 1'b0;
    branch_off = 8'h00;
    m_pc       = ResetPc;
    m_prev     = ResetPc;

    // Reset held two cycles with a jump pending
    @(negedge clk);
    @(negedge clk);
    chk("reset.pc", pc, ResetPc);
    chk_status("reset", 1'b0, 1'b0, 1'b0);
    chk_prev("reset");
    reset    = 1'b0;
    jump_req = 1'b0;
    @(negedge clk);
    chk("reset.jump_ignored", pc, ResetPc);
    chk_status("reset.after", 1'b0, 1'b0, 1'b0);

    // Increment with low-byte carry
    issue("jmp12fe", 1'b1, 1'b0, 1'b0, 16'h12FE, 8'h00, 1'b0);
    issue("inc_a",   1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
    issue("inc_b",   1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);

    // Trace check and priority: jump beats inc
    issue("jmp1234", 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0);
    issue("prio",    1'b1, 1'b0, 1'b1, 16'hC000, 8'h00, 1'b0);
    issue("prio_jb", 1'b1, 1'b1, 1'b1, 16'h20F0, 8'h7F, 1'b0);

    // Forward branches
    issue("fwd_x",   1'b0, 1'b1, 1'b0, 16'h0000, 8'h20, 1'b0);
    issue("jmp2010", 1'b1, 1'b0, 1'b0, 16'h2010, 8'h00, 1'b0);
    issue("fwd_nx",  1'b0, 1'b1, 1'b1, 16'h0000, 8'h20, 1'b0);

    // Backward branches, including a 16-bit wrap
    issue("jmp3005", 1'b1, 1'b0, 1'b0, 16'h3005, 8'h00, 1'b0);
    issue("bwd_x",   1'b0, 1'b1, 1'b0, 16'h0000, 8'hF0, 1'b0);
    issue("jmp0005", 1'b1, 1'b0, 1'b0, 16'h0005, 8'h00, 1'b0);
    issue("bwd_wrap", 1'b0, 1'b1, 1'b0, 16'h0000, 8'hF0, 1'b0);
    issue("br_zero", 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Full wrap and requests ignored while busy
    issue("jmpffff", 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0);
    issue("inc_wrap", 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
    issue("jmp12ff", 1'b1, 1'b0, 1'b0, 16'h12FF, 8'h00, 1'b0);
    issue("inc_busy", 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);

    // Reset while in the branch fix-up cycle
    issue("jmp20f0", 1'b1, 1'b0, 1'b0, 16'h20F0, 8'h00, 1'b0);
    branch_req = 1'b1;
    branch_off = 8'h20;
    @(negedge clk);
    branch_req = 1'b0;
    chk("rstmid.busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    m_pc   = ResetPc;
    m_prev = ResetPc;
    chk("rstmid.pc", pc, ResetPc);
    chk_status("rstmid", 1'b0, 1'b0, 1'b0);
    chk_prev("rstmid");
    @(negedge clk);
    chk("rstmid.hold", pc, ResetPc);
    chk_status("rstmid.next", 1'b0, 1'b0, 1'b0);

    // Random requests, biased toward page boundaries
    for (int k = 0; k < 400; k++) begin
      rj   = ($urandom_range(0, 3) == 0);
      rb   = ($urandom_range(0, 1) == 0);
      ri   = ($urandom_range(0, 1) == 0);
      radr = 16'($urandom);
      if ($urandom_range(0, 2) == 0) radr[7:0] = 8'hF8 + 8'($urandom_range(0, 7));
      roff = 8'($urandom);
      issue("rand", rj, rb, ri, radr, roff, ($urandom_range(0, 1) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
